// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      inst_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic             illegal_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, inst_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );

  modport slave (
    input  in_valid_i, inst_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate decoder behind a 2-entry skid buffer
// Define ZICSR_IMM_EN to decode CSR address / zimm immediates on the SYSTEM opcode.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  imm_gen_pipe_if.slave io
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [31:0]        inst;
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic               is_shift;
  logic signed [31:0] imm32;
  ent_t               dec;

  assign inst     = io.inst_i;
  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Every immediate fits in 32 bits once sign-extended, so decode narrow and widen once.
  always_comb begin
    imm32   = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    dec.tag = io.tag_i;
    case (opc)
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      OP_IMM: begin
        dec.fmt = is_shift ? FMT_SHAMT : FMT_I;
        imm32   = is_shift ? {26'b0, (XLEN == 64) & inst[25], inst[24:20]}
                           : {{20{inst[31]}}, inst[31:20]};
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          dec.fmt = is_shift ? FMT_SHAMT : FMT_I;
          imm32   = is_shift ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
        end else begin
          dec.ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_SYSTEM: begin
`ifdef ZICSR_IMM_EN
        if (f3[2] && (f3[1:0] != 2'b00)) begin
          dec.fmt = FMT_ZIMM;
          imm32   = {27'b0, inst[19:15]};
        end else if (!f3[2] && (f3[1:0] != 2'b00)) begin
          dec.fmt = FMT_I;
          imm32   = {20'b0, inst[31:20]};
        end
`else
        dec.fmt = FMT_NONE;
`endif
      end
      default: dec.ill = 1'b1;
    endcase
    dec.imm = XLEN'(imm32);
  end

  ent_t main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic accept;

  assign accept = io.in_valid_i && !skid_valid_q;

  // Skid is only ever occupied while main is held, so a drain always refills from skid first.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || io.out_ready_i) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign io.in_ready_o  = !skid_valid_q;
  assign io.out_valid_o = main_valid_q;
  assign io.imm_o       = main_q.imm;
  assign io.fmt_o       = main_q.fmt;
  assign io.illegal_o   = main_q.ill;
  assign io.tag_o       = main_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic [31:0] tag = '0;
  bit          run_cmp = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

  assign if32.in_valid_i  = in_valid;
  assign if32.inst_i      = inst;
  assign if32.tag_i       = tag;
  assign if32.out_ready_i = out_ready;
  assign if64.in_valid_i  = in_valid;
  assign if64.inst_i      = inst;
  assign if64.tag_i       = tag;
  assign if64.out_ready_i = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .io(if32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .io(if64));

  typedef struct {
    logic [31:0] w;
    logic [31:0] tag;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference decode from the ISA field layout using 64-bit arithmetic.
  function automatic void exp_dec(input logic [31:0] w, input int xl,
                                  output longint imm, output int fmt, output bit ill);
    longint s  = longint'($signed(w));
    longint u  = longint'({32'b0, w});
    int     op = int'(w[6:0]);
    int     f3 = int'(w[14:12]);
    bit     sh = (f3 == 1) || (f3 == 5);
    imm = 0; fmt = 0; ill = 0;
    case (op)
      'h03, 'h67: fmt = 1;
      'h13:       fmt = sh ? 6 : 1;
      'h1B:       if (xl == 64) fmt = sh ? 6 : 1; else ill = 1;
      'h23:       fmt = 2;
      'h63:       fmt = 3;
      'h37, 'h17: fmt = 4;
      'h6F:       fmt = 5;
      'h73: begin
`ifdef ZICSR_IMM_EN
        if (f3 >= 5) fmt = 7;
        else if (f3 >= 1 && f3 <= 3) fmt = 1;
`endif
      end
      default: ill = 1;
    endcase
    case (fmt)
      1: imm = (op == 'h73) ? (u >> 20) : (s >>> 20);
      2: imm = ((s >>> 25) << 5) | ((u >> 7) & 31);
      3: imm = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      4: imm = (s >>> 12) << 12;
      5: imm = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      6: imm = (u >> 20) & ((xl == 64 && op == 'h13) ? 63 : 31);
      7: imm = (u >> 15) & 31;
      default: imm = 0;
    endcase
    if (xl == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit acc, drn;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back('{w: inst, tag: tag});
      end
    end
  end

  always @(negedge clk) begin
    longint e;
    int     f;
    bit     il;
    if (rst_n && run_cmp) begin
      chk("valid32", longint'(if32.out_valid_o), longint'(q.size() > 0));
      chk("valid64", longint'(if64.out_valid_o), longint'(q.size() > 0));
      chk("ready32", longint'(if32.in_ready_o), longint'(q.size() < 2));
      chk("ready64", longint'(if64.in_ready_o), longint'(q.size() < 2));
      if (q.size() > 0) begin
        exp_dec(q[0].w, 32, e, f, il);
        chk("imm32", longint'(if32.imm_o), e);
        chk("fmt32", longint'(if32.fmt_o), longint'(f));
        chk("ill32", longint'(if32.illegal_o), longint'(il));
        chk("tag32", longint'(if32.tag_o), longint'(q[0].tag));
        exp_dec(q[0].w, 64, e, f, il);
        chk("imm64", longint'(if64.imm_o), e);
        chk("fmt64", longint'(if64.fmt_o), longint'(f));
        chk("ill64", longint'(if64.illegal_o), longint'(il));
        chk("tag64", longint'(if64.tag_o), longint'(q[0].tag));
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] t);
    bit rdy;
    int n = 0;
    in_valid = 1'b1; inst = w; tag = t;
    do begin
      @(negedge clk);
      rdy = if32.in_ready_o;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    chk("send_accepted", longint'(rdy), 1);
    in_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [31:0] w, input int xl,
                     input longint ei, input int ef, input bit eil);
    longint i;
    int     f;
    bit     il;
    exp_dec(w, xl, i, f, il);
    chk({nm, "_imm"}, i, ei);
    chk({nm, "_fmt"}, longint'(f), longint'(ef));
    chk({nm, "_ill"}, longint'(il), longint'(eil));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[13] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F, 7'h0B};
    logic [31:0] r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  initial begin
    pin("m_addi",  32'hFFF00093, 32, 64'hFFFF_FFFF, 1, 0);
    pin("m_srai",  32'h4030D093, 32, 64'h3, 6, 0);
    pin("m_lui",   32'h12345037, 32, 64'h1234_5000, 4, 0);
    pin("m_beq",   32'hFE000EE3, 32, 64'hFFFF_FFFC, 3, 0);
    pin("m_ill",   32'h0000007F, 32, 64'h0, 0, 1);
    pin("m_jal",   32'h0080006F, 32, 64'h8, 5, 0);
    pin("m_slli",  32'h03F09093, 64, 64'h3F, 6, 0);
    pin("m_jneg",  32'h8000006F, 64, 64'hFFFF_FFFF_FFF0_0000, 5, 0);
    pin("m_w32",   32'h0000001B, 32, 64'h0, 0, 1);
`ifdef ZICSR_IMM_EN
    pin("m_csr",   32'h3001D073, 32, 64'h3, 7, 0);
`else
    pin("m_csr",   32'h3001D073, 32, 64'h0, 0, 0);
`endif

    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid32", longint'(if32.out_valid_o), 0);
    chk("rst_valid64", longint'(if64.out_valid_o), 0);
    chk("rst_ready32", longint'(if32.in_ready_o), 1);
    chk("rst_imm64",   longint'(if64.imm_o), 0);
    chk("rst_fmt32",   longint'(if32.fmt_o), 0);
    chk("rst_ill32",   longint'(if32.illegal_o), 0);
    chk("rst_tag64",   longint'(if64.tag_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_cmp = 1'b1;

    send(32'hFFF00093, 32'h10);
    send(32'h4030D093, 32'h14);
    send(32'h12345037, 32'h18);
    send(32'hFE000EE3, 32'h1C);
    send(32'h0000007F, 32'h20);
    send(32'h0080006F, 32'h24);
    send(32'h03F09093, 32'h28);
    send(32'h8000006F, 32'h2C);
    send(32'h3001D073, 32'h30);
    repeat (3) @(posedge clk);

    #1 out_ready = 1'b0;
    send(32'h00100093, 32'h100);
    send(32'h00200113, 32'h104);
    in_valid = 1'b1; inst = 32'h00300193; tag = 32'h108;
    @(negedge clk);
    chk("bp_stall_ready", longint'(if32.in_ready_o), 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'h00300193, 32'h108);
    repeat (4) @(posedge clk);

    #1 out_ready = 1'b0;
    send(32'h00400213, 32'hF00);
    send(32'h00500293, 32'hF04);
    in_valid = 1'b1; inst = 32'h00600313; tag = 32'hF08; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", longint'(if64.out_valid_o), 0);
    chk("flush_ready", longint'(if64.in_ready_o), 1);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    repeat (2000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      inst      = rand_inst();
      tag       = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);

    #1 out_ready = 1'b0;
    send(32'h00700393, 32'h200);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid32", longint'(if32.out_valid_o), 0);
    chk("async_rst_valid64", longint'(if64.out_valid_o), 0);
    chk("async_rst_ready",   longint'(if32.in_ready_o), 1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
